cam_capture: RTL

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_capture.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cam_capture.sv
// cam_capture: turns an 8-bit camera byte stream (Href/Vsync framing) into RGB pixel writes.
// Define CAM_CAPTURE_STATS_EN to add the frame_cnt/err_cnt statistics outputs.
module cam_capture #(
  parameter  int OUT_FMT = 0,
  parameter  int IMG_W   = 160,
  parameter  int IMG_H   = 120,
  parameter  int AW      = 15,
  localparam int DW      = (OUT_FMT == 0) ? 8 : (OUT_FMT == 1) ? 12 : 16
) (
  input  logic          Pclk,
  input  logic          Rst_n,
  input  logic [7:0]    Data,
  input  logic          Href,
  input  logic          Vsync,
  input  logic          Enable,
  output logic          regWrite,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          frame_done,
  output logic          busy,
  output logic          overflow,
  output logic          line_err
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   err_cnt
`endif
);

  if (OUT_FMT < 0 || OUT_FMT > 2) begin : g_bad_fmt
    $error("cam_capture: OUT_FMT must be 0, 1 or 2");
  end
  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << AW)) begin : g_bad_size
    $error("cam_capture: IMG_W*IMG_H does not fit in AW address bits");
  end

  // col saturates at IMG_W+1 so an over-long line still differs from IMG_W
  localparam int CW = $clog2(IMG_W + 2);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H);

  typedef enum logic [2:0] {IDLE, ARMED, SYNC, CAPTURE, DONE} state_t;

  state_t        state;
  logic          phase;
  logic          href_q;
  logic [7:0]    byte0_p0;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] row_base;

  function automatic logic [DW-1:0] pack_pixel(input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] p;
    if (OUT_FMT == 0)      p = {8'h00, b0[7:5], b0[2:0], b1[4:3]};
    else if (OUT_FMT == 1) p = {4'h0, b0[7:4], b0[2:0], b1[7], b1[4:1]};
    else                   p = {b0, b1};
    return p[DW-1:0];
  endfunction

  // Stage p0: first byte of the pixel is held until its partner arrives
  always_ff @(posedge Pclk) begin
    if (state == CAPTURE && !Vsync && Href && !phase) byte0_p0 <= Data;
  end

  always_ff @(posedge Pclk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      regWrite   <= 1'b0;
      addr_in    <= '0;
      data_in    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      line_err   <= 1'b0;
      phase      <= 1'b0;
      href_q     <= 1'b0;
      col        <= '0;
      row        <= '0;
      row_base   <= '0;
    end else begin
      regWrite   <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      case (state)
        IDLE: if (Enable) state <= ARMED;
        ARMED: begin
          if (!Enable)    state <= IDLE;
          else if (Vsync) state <= SYNC;
        end
        SYNC: begin
          if (!Enable) state <= IDLE;
          else if (!Vsync) begin
            state    <= CAPTURE;
            busy     <= 1'b1;
            overflow <= 1'b0;
            row_base <= '0;
            row      <= '0;
            col      <= '0;
            phase    <= 1'b0;
            href_q   <= 1'b0;
          end
        end
        CAPTURE: begin
          if (Vsync) begin
            // any half pixel in flight is discarded here
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            phase      <= 1'b0;
            href_q     <= 1'b0;
          end else begin
            href_q <= Href;
            if (Href) begin
              phase <= ~phase;
              if (phase) begin
                // Stage p1: pixel complete, write it out or flag it as out of frame
                if (col < COL_MAX && row < ROW_MAX) begin
                  regWrite <= 1'b1;
                  addr_in  <= row_base + AW'(col);
                  data_in  <= pack_pixel(byte0_p0, Data);
                end else begin
                  overflow <= 1'b1;
                end
                if (col <= COL_MAX) col <= col + 1'b1;
              end
            end else if (href_q) begin
              line_err <= phase | (col != COL_MAX);
              phase    <= 1'b0;
              col      <= '0;
              row_base <= row_base + AW'(IMG_W);
              if (row < ROW_MAX) row <= row + 1'b1;
            end
          end
        end
        DONE:    state <= Enable ? ARMED : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CAM_CAPTURE_STATS_EN
  always_ff @(posedge Pclk or negedge Rst_n) begin
    if (!Rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (line_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
